// File: rtl/gige_rx_gmii.sv
// gige_rx_gmii: GMII receive front end; strips preamble/SFD, packs frame bytes (FCS included) into 64-bit LE words, reports EOF status and good-frame statistics.
// Latency: rx_wen/rx_data 2 cycles after a word's last byte at the pins; rx_eof/status 3 cycles after dv drops; counters 1 cycle after rx_eof.
// Backpressure: none; the PHY cannot be stalled, so the consumer must take every rx_wen strobe. Optional FCS check: define GIGE_RX_CRC_CHK_EN.
module gige_rx_gmii #(
    parameter int MAX_BYTES = 1522
) (
    input  logic        clk125,
    input  logic        rst,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic        rx_wen,
    output logic [63:0] rx_data,
    output logic        rx_eof,
    output logic [15:0] rx_bytes,
    output logic        rx_err,
    output logic        rx_crc_err,
    output logic [31:0] FMAC_RX_PKT_CNT,
    output logic [31:0] FMAC_RX_BYTE_CNT,
    input  logic        fmac_rx_clr_en
);

    localparam logic [15:0] MAX_B  = 16'(MAX_BYTES);
    localparam logic [15:0] MIN_B  = 16'd64;

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        PREAMBLE = 4'b0010,
        DATA     = 4'b0100,
        DROP     = 4'b1000
    } state_t;

    // Input stage S1
    logic [7:0]  s1_rxd_q;
    logic        s1_dv_q, s1_er_q, s1_clr_q;

    // Frame tracking and packing
    state_t      state_q, state_d;
    logic [2:0]  lane_q, lane_d;
    logic [15:0] cnt_q, cnt_d;
    logic [63:0] word_q, word_d, word_ins;
    logic        over_q, over_d;
    logic        er_seen_q, er_seen_d;

    // Word emit stage and EOF pipeline
    logic        emit_vld_q, emit_vld_d;
    logic [63:0] emit_dat_q, emit_dat_d;
    logic        eof_p_q, eof_p_d;
    logic        eof_m_q;
    logic [15:0] eof_bytes_q, eof_bytes_d;
    logic        eof_err_q, eof_err_d;
    logic        eof_crc_q, eof_crc_d;
    logic        crc_bad;

    // Output registers
    logic        rx_wen_q, rx_wen_d;
    logic [63:0] rx_data_q, rx_data_d;
    logic        rx_eof_q, rx_eof_d;
    logic [15:0] rx_bytes_q, rx_bytes_d;
    logic        rx_err_q, rx_err_d;
    logic        rx_crc_err_q, rx_crc_err_d;
    logic [31:0] pkt_q, pkt_d;
    logic [31:0] byt_q, byt_d;

`ifdef GIGE_RX_CRC_CHK_EN
    logic [31:0] crc_q, crc_d;

    // Reflected CRC-32 update for one byte, LSB first
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        end
        return x;
    endfunction

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // The register holds the reflected residue; compare in the normal bit order
    assign crc_bad = (bit_rev(crc_q) != 32'hC704DD7B);
`else
    assign crc_bad = 1'b0;
`endif

    // S1 has no reset so a frame still on the wire keeps dv high through reset and the FSM waits in DROP for a real dv=0
    always_ff @(posedge clk125) begin
        s1_rxd_q <= gmii_rxd;
        s1_dv_q  <= gmii_rx_dv;
        s1_er_q  <= gmii_rx_er;
        s1_clr_q <= fmac_rx_clr_en;
    end

    // Next-state, byte packing and EOF capture from the S1 copies
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        over_d      = over_q;
        er_seen_d   = er_seen_q;
        emit_vld_d  = 1'b0;
        emit_dat_d  = emit_dat_q;
        eof_p_d     = 1'b0;
        eof_bytes_d = eof_bytes_q;
        eof_err_d   = eof_err_q;
        eof_crc_d   = eof_crc_q;
        word_ins    = word_q;
        word_ins[{lane_q, 3'b000} +: 8] = s1_rxd_q;
`ifdef GIGE_RX_CRC_CHK_EN
        crc_d       = crc_q;
`endif
        case (state_q)
            IDLE: begin
                if (s1_dv_q) begin
                    state_d = (s1_rxd_q == 8'h55) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!s1_dv_q || s1_er_q) begin
                    state_d = DROP;
                end else if (s1_rxd_q == 8'hD5) begin
                    state_d   = DATA;
                    lane_d    = 3'd0;
                    cnt_d     = 16'd0;
                    word_d    = '0;
                    over_d    = 1'b0;
                    er_seen_d = 1'b0;
`ifdef GIGE_RX_CRC_CHK_EN
                    crc_d     = 32'hFFFFFFFF;
`endif
                end else if (s1_rxd_q != 8'h55) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (s1_dv_q) begin
                    er_seen_d = er_seen_q | s1_er_q;
`ifdef GIGE_RX_CRC_CHK_EN
                    crc_d     = crc_byte(crc_q, s1_rxd_q);
`endif
                    // Bytes past the length limit are counted as oversize but never written
                    if (cnt_q < MAX_B) begin
                        cnt_d  = cnt_q + 16'd1;
                        lane_d = lane_q + 3'd1;
                        if (lane_q == 3'd7) begin
                            emit_vld_d = 1'b1;
                            emit_dat_d = word_ins;
                            word_d     = '0;
                        end else begin
                            word_d     = word_ins;
                        end
                    end else begin
                        over_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    if (lane_q != 3'd0) begin
                        emit_vld_d = 1'b1;
                        emit_dat_d = word_q;
                    end
                    word_d      = '0;
                    eof_p_d     = 1'b1;
                    eof_bytes_d = cnt_q;
                    eof_err_d   = (cnt_q < MIN_B) | over_q | er_seen_q;
                    eof_crc_d   = crc_bad;
                end
            end
            DROP: begin
                if (!s1_dv_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = DROP;
        endcase
    end

    // Output strobes/status and statistics; clear has priority over a good-frame update
    always_comb begin
        rx_wen_d     = emit_vld_q;
        rx_data_d    = emit_vld_q ? emit_dat_q : rx_data_q;
        rx_eof_d     = eof_m_q;
        rx_bytes_d   = eof_m_q ? eof_bytes_q : rx_bytes_q;
        rx_err_d     = eof_m_q ? (eof_err_q | eof_crc_q) : rx_err_q;
        rx_crc_err_d = eof_m_q ? eof_crc_q : rx_crc_err_q;
        pkt_d        = pkt_q;
        byt_d        = byt_q;
        if (s1_clr_q) begin
            pkt_d = '0;
            byt_d = '0;
        end else if (rx_eof_q && !rx_err_q) begin
            pkt_d = pkt_q + 32'd1;
            byt_d = byt_q + {16'd0, rx_bytes_q};
        end
    end

    // All frame state, pipeline and output flops
    always_ff @(posedge clk125) begin
        if (rst) begin
            state_q      <= DROP;
            lane_q       <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            over_q       <= 1'b0;
            er_seen_q    <= 1'b0;
            emit_vld_q   <= 1'b0;
            emit_dat_q   <= '0;
            eof_p_q      <= 1'b0;
            eof_m_q      <= 1'b0;
            eof_bytes_q  <= '0;
            eof_err_q    <= 1'b0;
            eof_crc_q    <= 1'b0;
            rx_wen_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_eof_q     <= 1'b0;
            rx_bytes_q   <= '0;
            rx_err_q     <= 1'b0;
            rx_crc_err_q <= 1'b0;
            pkt_q        <= '0;
            byt_q        <= '0;
`ifdef GIGE_RX_CRC_CHK_EN
            crc_q        <= 32'hFFFFFFFF;
`endif
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            over_q       <= over_d;
            er_seen_q    <= er_seen_d;
            emit_vld_q   <= emit_vld_d;
            emit_dat_q   <= emit_dat_d;
            eof_p_q      <= eof_p_d;
            eof_m_q      <= eof_p_q;
            eof_bytes_q  <= eof_bytes_d;
            eof_err_q    <= eof_err_d;
            eof_crc_q    <= eof_crc_d;
            rx_wen_q     <= rx_wen_d;
            rx_data_q    <= rx_data_d;
            rx_eof_q     <= rx_eof_d;
            rx_bytes_q   <= rx_bytes_d;
            rx_err_q     <= rx_err_d;
            rx_crc_err_q <= rx_crc_err_d;
            pkt_q        <= pkt_d;
            byt_q        <= byt_d;
`ifdef GIGE_RX_CRC_CHK_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign rx_wen           = rx_wen_q;
    assign rx_data          = rx_data_q;
    assign rx_eof           = rx_eof_q;
    assign rx_bytes         = rx_bytes_q;
    assign rx_err           = rx_err_q;
    assign rx_crc_err       = rx_crc_err_q;
    assign FMAC_RX_PKT_CNT  = pkt_q;
    assign FMAC_RX_BYTE_CNT = byt_q;

endmodule

// File: tb/tb_gige_rx_gmii.sv
// tb_gige_rx_gmii: directed frames into gige_rx_gmii with hand-computed expectations.
// Latency: checks word, EOF and counter timing relative to the dv=0 pin edge.
// Backpressure: none in the DUT; the bench records every rx_wen/rx_eof strobe as it appears.
module tb_gige_rx_gmii;

    logic        clk125 = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic        fmac_rx_clr_en = 1'b0;
    logic        rx_wen;
    logic [63:0] rx_data;
    logic        rx_eof;
    logic [15:0] rx_bytes;
    logic        rx_err;
    logic        rx_crc_err;
    logic [31:0] pkt_cnt;
    logic [31:0] byt_cnt;

    gige_rx_gmii dut (
        .clk125           (clk125),
        .rst              (rst),
        .gmii_rxd         (gmii_rxd),
        .gmii_rx_dv       (gmii_rx_dv),
        .gmii_rx_er       (gmii_rx_er),
        .rx_wen           (rx_wen),
        .rx_data          (rx_data),
        .rx_eof           (rx_eof),
        .rx_bytes         (rx_bytes),
        .rx_err           (rx_err),
        .rx_crc_err       (rx_crc_err),
        .FMAC_RX_PKT_CNT  (pkt_cnt),
        .FMAC_RX_BYTE_CNT (byt_cnt),
        .fmac_rx_clr_en   (fmac_rx_clr_en)
    );

    always #4 clk125 = ~clk125;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wen_cnt = 0;
    int eof_cnt = 0;
    int wen_cyc = 0;
    int eof_cyc = 0;
    int end_cyc = 0;
    int wb, eb;
    int exp_pkt, exp_byt;
    logic exp_crc;
    logic [63:0] words [0:1023];
    logic [7:0]  frm   [0:1599];

    always @(posedge clk125) cyc <= cyc + 1;

    always @(negedge clk125) begin
        if (rx_wen) begin
            words[wen_cnt % 1024] = rx_data;
            wen_cnt = wen_cnt + 1;
            wen_cyc = cyc;
        end
        if (rx_eof) begin
            eof_cnt = eof_cnt + 1;
            eof_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    // Payload pattern plus a valid FCS; optionally flip bit 0 of one byte afterwards
    task automatic build_frame(input int n, input int flip_idx);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            frm[i] = 8'(i * 37 + 11) ^ 8'(n);
            c = crc_upd(c, frm[i]);
        end
        c = ~c;
        frm[n-4] = c[7:0];
        frm[n-3] = c[15:8];
        frm[n-2] = c[23:16];
        frm[n-1] = c[31:24];
        if (flip_idx >= 0) frm[flip_idx] = frm[flip_idx] ^ 8'h01;
    endtask

    function automatic logic [63:0] pack8(input int base, input int nb);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < nb; j++) w[8*j +: 8] = frm[base + j];
        return w;
    endfunction

    task automatic drive_byte(input logic dv, input logic [7:0] d, input logic er);
        @(posedge clk125);
        #1;
        gmii_rx_dv = dv;
        gmii_rxd   = d;
        gmii_rx_er = er;
    endtask

    task automatic send_frame(input int n, input int bad_pre_idx, input int er_idx);
        for (int i = 0; i < 7; i++) drive_byte(1'b1, (i == bad_pre_idx) ? 8'h5A : 8'h55, 1'b0);
        drive_byte(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < n; i++) drive_byte(1'b1, frm[i], (i == er_idx));
        drive_byte(1'b0, 8'h00, 1'b0);
        end_cyc = cyc;
    endtask

    task automatic wait_eof(input int target);
        for (int i = 0; i < 40; i++) begin
            if (eof_cnt >= target) break;
            @(posedge clk125);
        end
        repeat (4) @(posedge clk125);
        @(negedge clk125);
        chk("eof_count", 64'(eof_cnt), 64'(target));
    endtask

    initial begin
        // Reset state
        repeat (5) @(posedge clk125);
        @(negedge clk125);
        chk("rst_wen",   64'(rx_wen), 64'd0);
        chk("rst_eof",   64'(rx_eof), 64'd0);
        chk("rst_bytes", 64'(rx_bytes), 64'd0);
        chk("rst_err",   64'(rx_err), 64'd0);
        chk("rst_crc",   64'(rx_crc_err), 64'd0);
        chk("rst_pkt",   64'(pkt_cnt), 64'd0);
        chk("rst_byt",   64'(byt_cnt), 64'd0);
        @(posedge clk125);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk125);

        // Good 64-byte frame
        build_frame(64, -1);
        wb = wen_cnt; eb = eof_cnt;
        send_frame(64, -1, -1);
        wait_eof(eb + 1);
        chk("g64_wen_n",    64'(wen_cnt - wb), 64'd8);
        chk("g64_word0",    words[wb % 1024], pack8(0, 8));
        chk("g64_word7",    words[(wb + 7) % 1024], pack8(56, 8));
        chk("g64_wen_lat",  64'(wen_cyc - end_cyc), 64'd2);
        chk("g64_eof_lat",  64'(eof_cyc - end_cyc), 64'd4);
        chk("g64_bytes",    64'(rx_bytes), 64'd64);
        chk("g64_err",      64'(rx_err), 64'd0);
        chk("g64_crc",      64'(rx_crc_err), 64'd0);
        chk("g64_pkt",      64'(pkt_cnt), 64'd1);
        chk("g64_byt",      64'(byt_cnt), 64'd64);

        // Good 67-byte frame: partial last word
        build_frame(67, -1);
        wb = wen_cnt; eb = eof_cnt;
        send_frame(67, -1, -1);
        wait_eof(eb + 1);
        chk("g67_wen_n",    64'(wen_cnt - wb), 64'd9);
        chk("g67_upper0",   {24'd0, words[(wb + 8) % 1024][63:24]}, 64'd0);
        chk("g67_last",     words[(wb + 8) % 1024], pack8(64, 3));
        chk("g67_wen_lat",  64'(wen_cyc - end_cyc), 64'd3);
        chk("g67_bytes",    64'(rx_bytes), 64'd67);
        chk("g67_err",      64'(rx_err), 64'd0);
        chk("g67_pkt",      64'(pkt_cnt), 64'd2);
        chk("g67_byt",      64'(byt_cnt), 64'd131);
        repeat (20) @(posedge clk125);
        @(negedge clk125);
        chk("g67_hold",     64'(rx_bytes), 64'd67);
        exp_pkt = 2; exp_byt = 131;

        // Corrupted FCS
`ifdef GIGE_RX_CRC_CHK_EN
        exp_crc = 1'b1;
`else
        exp_crc = 1'b0;
        exp_pkt = 3; exp_byt = 195;
`endif
        build_frame(64, 10);
        eb = eof_cnt;
        send_frame(64, -1, -1);
        wait_eof(eb + 1);
        chk("fcs_crc",  64'(rx_crc_err), 64'(exp_crc));
        chk("fcs_err",  64'(rx_err), 64'(exp_crc));
        chk("fcs_pkt",  64'(pkt_cnt), 64'(exp_pkt));
        chk("fcs_byt",  64'(byt_cnt), 64'(exp_byt));

        // rx_er mid-DATA
        build_frame(64, -1);
        eb = eof_cnt;
        send_frame(64, -1, 20);
        wait_eof(eb + 1);
        chk("er_err",   64'(rx_err), 64'd1);
        chk("er_crc",   64'(rx_crc_err), 64'd0);
        chk("er_bytes", 64'(rx_bytes), 64'd64);
        chk("er_pkt",   64'(pkt_cnt), 64'(exp_pkt));

        // Bad preamble byte: frame dropped silently
        wb = wen_cnt; eb = eof_cnt;
        send_frame(64, 3, -1);
        repeat (30) @(posedge clk125);
        @(negedge clk125);
        chk("pre_eof_n", 64'(eof_cnt), 64'(eb));
        chk("pre_wen_n", 64'(wen_cnt), 64'(wb));

        // 40-byte runt
        build_frame(40, -1);
        wb = wen_cnt; eb = eof_cnt;
        send_frame(40, -1, -1);
        wait_eof(eb + 1);
        chk("runt_bytes", 64'(rx_bytes), 64'd40);
        chk("runt_err",   64'(rx_err), 64'd1);
        chk("runt_wen_n", 64'(wen_cnt - wb), 64'd5);
        chk("runt_pkt",   64'(pkt_cnt), 64'(exp_pkt));

        // 1600-byte oversize frame
        build_frame(1600, -1);
        wb = wen_cnt; eb = eof_cnt;
        send_frame(1600, -1, -1);
        wait_eof(eb + 1);
        chk("big_bytes", 64'(rx_bytes), 64'd1522);
        chk("big_err",   64'(rx_err), 64'd1);
        chk("big_wen_n", 64'(wen_cnt - wb), 64'd191);
        chk("big_last",  words[(wb + 190) % 1024], pack8(1520, 2));
        chk("big_byt",   64'(byt_cnt), 64'(exp_byt));

        // Back-to-back frames with one idle cycle
        build_frame(64, -1);
        wb = wen_cnt; eb = eof_cnt;
        send_frame(64, -1, -1);
        send_frame(64, -1, -1);
        wait_eof(eb + 2);
        chk("b2b_wen_n", 64'(wen_cnt - wb), 64'd16);
        chk("b2b_pkt",   64'(pkt_cnt), 64'(exp_pkt + 2));
        chk("b2b_byt",   64'(byt_cnt), 64'(exp_byt + 128));

        // Statistics clear
        @(posedge clk125);
        #1 fmac_rx_clr_en = 1'b1;
        @(posedge clk125);
        #1 fmac_rx_clr_en = 1'b0;
        repeat (3) @(posedge clk125);
        @(negedge clk125);
        chk("clr_pkt", 64'(pkt_cnt), 64'd0);
        chk("clr_byt", 64'(byt_cnt), 64'd0);

        // Reset mid-frame: no EOF, and nothing until dv drops
        build_frame(100, -1);
        for (int i = 0; i < 7; i++) drive_byte(1'b1, 8'h55, 1'b0);
        drive_byte(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 20; i++) drive_byte(1'b1, frm[i], 1'b0);
        rst = 1'b1;
        drive_byte(1'b1, 8'h55, 1'b0);
        wb = wen_cnt; eb = eof_cnt;
        drive_byte(1'b1, 8'h55, 1'b0);
        drive_byte(1'b1, 8'hD5, 1'b0);
        rst = 1'b0;
        drive_byte(1'b1, 8'h55, 1'b0);
        drive_byte(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 70; i++) drive_byte(1'b1, frm[i], 1'b0);
        drive_byte(1'b0, 8'h00, 1'b0);
        repeat (30) @(posedge clk125);
        @(negedge clk125);
        chk("mrst_eof_n", 64'(eof_cnt), 64'(eb));
        chk("mrst_wen_n", 64'(wen_cnt), 64'(wb));
        chk("mrst_pkt",   64'(pkt_cnt), 64'd0);

        // Reception resumes after reset
        build_frame(64, -1);
        eb = eof_cnt;
        send_frame(64, -1, -1);
        wait_eof(eb + 1);
        chk("post_err", 64'(rx_err), 64'd0);
        chk("post_pkt", 64'(pkt_cnt), 64'd1);
        chk("post_byt", 64'(byt_cnt), 64'd64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
